// File: rtl/ram_bank_pkg.sv
// rtl/ram_bank_pkg.sv - shared types and helpers for the byte-enable RAM bank
package ram_bank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    function automatic int lane_count(input int width);
        return width / BYTE_W;
    endfunction

    // Bit that makes the byte plus parity hold an even number of ones.
    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// rtl/ram_read_pipe.sv - LATENCY-deep data/valid shift register; data stages load only on valid
module ram_read_pipe #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q [LATENCY];
    logic [LATENCY-1:0] valid_q;

    // Data stages hold when no valid passes, so the output keeps its last result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_bank_be.sv
// rtl/ram_bank_be.sv - byte-enable RAM bank with hardware clear and registered reads; RAM_BANK_PARITY_EN adds per-lane parity
module ram_bank_be
    import ram_bank_pkg::*;
#(
    parameter int Data_width   = 16,
    parameter int RAM_depth    = 256,
    parameter int READ_LATENCY = 1,
    parameter int AW           = $clog2(RAM_depth)
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         WE,
    input  logic [AW-1:0]                WAddr,
    input  logic [Data_width/BYTE_W-1:0] BE,
    input  logic [Data_width-1:0]        Data_in,
    input  logic                         RE,
    input  logic [AW-1:0]                RAddr,
    output logic [Data_width-1:0]        Data_out,
    output logic                         RValid,
    output logic                         Busy
`ifdef RAM_BANK_PARITY_EN
    ,
    output logic                         Parity_err
`endif
);

    localparam int NB = lane_count(Data_width);
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(RAM_depth);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_depth - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [Data_width-1:0] mem [RAM_depth];

    logic waddr_ok, raddr_ok, wr_en, rd_en;
    logic [Data_width-1:0] rd_data;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end
    end

    assign waddr_ok = ({1'b0, WAddr} < DEPTH_LIM);
    assign raddr_ok = ({1'b0, RAddr} < DEPTH_LIM);
    assign wr_en    = (state_q == READY) && WE && waddr_ok;
    assign rd_en    = (state_q == READY) && RE;
    assign Busy     = (state_q == CLEAR);

    // Array read happens before the same-edge write lands, giving read-first collisions.
    assign rd_data  = raddr_ok ? mem[RAddr] : '0;

    always_ff @(posedge Clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (BE[i]) begin
                    mem[WAddr][i*BYTE_W +: BYTE_W] <= Data_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    ram_read_pipe #(
        .WIDTH   (Data_width),
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .valid_i (rd_en),
        .data_i  (rd_data),
        .valid_o (RValid),
        .data_o  (Data_out)
    );

`ifdef RAM_BANK_PARITY_EN
    logic [NB-1:0] par_mem [RAM_depth];
    logic          rd_perr;
    logic          perr_valid, perr_data;

    always_ff @(posedge Clk) begin
        if (state_q == CLEAR) begin
            par_mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (BE[i]) begin
                    par_mem[WAddr][i] <= even_parity(Data_in[i*BYTE_W +: BYTE_W]);
                end
            end
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        if (raddr_ok) begin
            for (int i = 0; i < NB; i++) begin
                rd_perr = rd_perr | (par_mem[RAddr][i] != even_parity(mem[RAddr][i*BYTE_W +: BYTE_W]));
            end
        end
    end

    ram_read_pipe #(
        .WIDTH   (1),
        .LATENCY (READ_LATENCY)
    ) u_parity_pipe (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .valid_i (rd_en),
        .data_i  (rd_perr),
        .valid_o (perr_valid),
        .data_o  (perr_data)
    );

    assign Parity_err = perr_valid & perr_data;
`endif

endmodule

// File: tb/tb_ram_bank_be.sv
// tb/tb_ram_bank_be.sv - randomized and directed checks of ram_bank_be (depth 256/lat 1 and depth 200/lat 2)
module tb_ram_bank_be;

    localparam int DEP [2] = '{256, 200};
    localparam int LAT [2] = '{1, 2};

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        WE = 1'b0, RE = 1'b0;
    logic [7:0]  WAddr = '0, RAddr = '0;
    logic [1:0]  BE = '0;
    logic [15:0] Data_in = '0;

    logic [15:0] d0_out, d1_out;
    logic        rv0, rv1, bz0, bz1;
`ifdef RAM_BANK_PARITY_EN
    logic        pe0, pe1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    ram_bank_be #(.Data_width(16), .RAM_depth(256), .READ_LATENCY(1)) dut0 (
        .Clk(Clk), .Rst(Rst), .WE(WE), .WAddr(WAddr), .BE(BE), .Data_in(Data_in),
        .RE(RE), .RAddr(RAddr), .Data_out(d0_out), .RValid(rv0), .Busy(bz0)
`ifdef RAM_BANK_PARITY_EN
        , .Parity_err(pe0)
`endif
    );

    ram_bank_be #(.Data_width(16), .RAM_depth(200), .READ_LATENCY(2)) dut1 (
        .Clk(Clk), .Rst(Rst), .WE(WE), .WAddr(WAddr), .BE(BE), .Data_in(Data_in),
        .RE(RE), .RAddr(RAddr), .Data_out(d1_out), .RValid(rv1), .Busy(bz1)
`ifdef RAM_BANK_PARITY_EN
        , .Parity_err(pe1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image per instance plus a queue of reads in flight.
    typedef struct {
        int          inst;
        int          due;
        logic [15:0] d;
        logic        p;
    } rd_t;

    logic [15:0] mm [2][256];
    bit          flip [256];
    rd_t         pq [$];
    int          ecnt;
    logic [15:0] e_d [2];
    logic        e_v [2];
    logic        e_b [2];
    logic        e_p [2];

    always @(posedge Clk or posedge Rst) begin
        rd_t r;
        if (Rst) begin
            ecnt = 0;
            pq.delete();
            for (int i = 0; i < 2; i++) begin
                e_d[i] = '0; e_v[i] = 1'b0; e_b[i] = 1'b1; e_p[i] = 1'b0;
                for (int a = 0; a < 256; a++) mm[i][a] = '0;
            end
            for (int a = 0; a < 256; a++) flip[a] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ecnt >= DEP[i] && RE) begin
                    r.inst = i;
                    r.due  = ecnt + LAT[i] - 1;
                    r.d    = (int'(RAddr) < DEP[i]) ? mm[i][RAddr] : 16'h0000;
                    r.p    = (i == 0) && flip[RAddr];
                    pq.push_back(r);
                end
            end
            for (int i = 0; i < 2; i++) begin
                e_v[i] = 1'b0; e_p[i] = 1'b0;
            end
            for (int k = pq.size() - 1; k >= 0; k--) begin
                if (pq[k].due == ecnt) begin
                    e_v[pq[k].inst] = 1'b1;
                    e_d[pq[k].inst] = pq[k].d;
                    e_p[pq[k].inst] = pq[k].p;
                    pq.delete(k);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (ecnt >= DEP[i] && WE && int'(WAddr) < DEP[i]) begin
                    for (int b = 0; b < 2; b++) begin
                        if (BE[b]) mm[i][WAddr][8*b +: 8] = Data_in[8*b +: 8];
                    end
                    if (i == 0 && BE[0]) flip[WAddr] = 1'b0;
                end
            end
            ecnt++;
            for (int i = 0; i < 2; i++) e_b[i] = (ecnt < DEP[i]);
        end
    end

    always @(negedge Clk) begin
        chk("busy0",  32'(bz0),    32'(e_b[0]));
        chk("rv0",    32'(rv0),    32'(e_v[0]));
        chk("dout0",  32'(d0_out), 32'(e_d[0]));
        chk("busy1",  32'(bz1),    32'(e_b[1]));
        chk("rv1",    32'(rv1),    32'(e_v[1]));
        chk("dout1",  32'(d1_out), 32'(e_d[1]));
`ifdef RAM_BANK_PARITY_EN
        chk("perr0",  32'(pe0),    32'(e_p[0]));
        chk("perr1",  32'(pe1),    32'(e_p[1]));
`endif
    end

    task automatic rw(input logic we, input logic [7:0] wa, input logic [15:0] wd, input logic [1:0] be,
                      input logic re, input logic [7:0] ra, input logic [15:0] x0, input logic [15:0] x1,
                      input string nm);
        @(negedge Clk);
        WE = we; WAddr = wa; Data_in = wd; BE = be; RE = re; RAddr = ra;
        @(negedge Clk);
        WE = 1'b0; RE = 1'b0;
        if (re) begin
            chk({nm, "_rv0"}, 32'(rv0), 32'd1);
            chk({nm, "_d0"},  32'(d0_out), 32'(x0));
            chk({nm, "_rv1_early"}, 32'(rv1), 32'd0);
        end
        @(negedge Clk);
        if (re) begin
            chk({nm, "_rv1"}, 32'(rv1), 32'd1);
            chk({nm, "_d1"},  32'(d1_out), 32'(x1));
            chk({nm, "_rv0_once"}, 32'(rv0), 32'd0);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        rw(1'b1, a, d, be, 1'b0, 8'h00, 16'h0000, 16'h0000, "wr");
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] x0, input logic [15:0] x1, input string nm);
        rw(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, a, x0, x1, nm);
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        #2 Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_busy0", 32'(bz0), 32'd1);
        chk("rst_rv0",   32'(rv0), 32'd0);
        chk("rst_d0",    32'(d0_out), 32'd0);
        chk("rst_rv1",   32'(rv1), 32'd0);
        Rst = 1'b0;
    endtask

    task automatic wait_clear(input bit req10);
        int c0, c1;
        c0 = int'(bz0);
        c1 = int'(bz1);
        for (int k = 1; k <= 400; k++) begin
            @(negedge Clk);
            if (bz0) c0++;
            if (bz1) c1++;
            if (req10 && k == 10) begin
                WE = 1'b1; RE = 1'b1; WAddr = 8'h20; RAddr = 8'h20; BE = 2'b11; Data_in = 16'hBEEF;
            end
            if (req10 && k == 11) begin
                WE = 1'b0; RE = 1'b0;
            end
            if (!bz0 && !bz1) break;
        end
        chk("clear_len0", 32'(c0), 32'd256);
        chk("clear_len1", 32'(c1), 32'd200);
    endtask

    initial begin
        reset_pulse();
        wait_clear(1'b1);
        rd(8'h7F, 16'h0000, 16'h0000, "clr7f");
        rd(8'h20, 16'h0000, 16'h0000, "clr20");

        wr(8'd5, 16'hABCD, 2'b11);
        wr(8'd5, 16'h1200, 2'b10);
        rd(8'd5, 16'h12CD, 16'h12CD, "be5");
        wr(8'd5, 16'hFFFF, 2'b00);
        rd(8'd5, 16'h12CD, 16'h12CD, "be0");

        wr(8'd9, 16'h0001, 2'b11);
        rw(1'b1, 8'd9, 16'h00FF, 2'b11, 1'b1, 8'd9, 16'h0001, 16'h0001, "coll");
        rd(8'd9, 16'h00FF, 16'h00FF, "coll_after");

        for (int a = 1; a <= 4; a++) wr(8'(a), 16'(a * 'h11), 2'b11);
        for (int k = 0; k <= 5; k++) begin
            @(negedge Clk);
            if (k >= 1 && k <= 4) begin
                chk("b2b_rv0", 32'(rv0), 32'd1);
                chk("b2b_d0",  32'(d0_out), 32'(k * 'h11));
            end
            if (k >= 2) begin
                chk("b2b_rv1", 32'(rv1), 32'd1);
                chk("b2b_d1",  32'(d1_out), 32'((k - 1) * 'h11));
            end
            RE = (k < 4); RAddr = 8'(k + 1);
        end
        RE = 1'b0;

        wr(8'd210, 16'h5A5A, 2'b11);
        rd(8'd210, 16'h5A5A, 16'h0000, "oor210");

`ifdef RAM_BANK_PARITY_EN
        wr(8'd3, 16'h1234, 2'b11);
        @(negedge Clk);
        dut0.par_mem[3][0] = ~dut0.par_mem[3][0];
        flip[3] = 1'b1;
        RE = 1'b1; RAddr = 8'd3;
        @(negedge Clk);
        RE = 1'b0;
        chk("par_err", 32'(pe0), 32'd1);
        chk("par_rv",  32'(rv0), 32'd1);
        wr(8'd3, 16'h0034, 2'b01);
        rd(8'd3, 16'h1234, 16'h1234, "par_fixed");
`endif

        for (int k = 0; k <= 3; k++) begin
            @(negedge Clk);
            if (k >= 1) chk("mid_d0", 32'(d0_out), 32'(k * 'h11));
            if (k == 3) begin
                RE = 1'b1; RAddr = 8'd4;
                #2 Rst = 1'b1;
            end else begin
                RE = 1'b1; RAddr = 8'(k + 1);
            end
        end
        RE = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("killed_rv0", 32'(rv0), 32'd0);
            chk("killed_rv1", 32'(rv1), 32'd0);
        end
        Rst = 1'b0;
        repeat (50) @(negedge Clk);
        reset_pulse();
        wait_clear(1'b0);
        rd(8'd1, 16'h0000, 16'h0000, "reclear1");

        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            WE      = 1'($urandom_range(0, 1));
            RE      = 1'($urandom_range(0, 1));
            WAddr   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            RAddr   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            BE      = 2'($urandom_range(0, 3));
            Data_in = 16'($urandom);
        end
        @(negedge Clk);
        WE = 1'b0; RE = 1'b0;
        repeat (4) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
